fluid_dispense_scheduler: RTL

Shares one fluid dispenser nozzle between N_REQ user stations. It arbitrates requests round-robin and checks per-fluid stock. It then paces the pour one litre at a time, decrementing stock as it goes. Stock levels feed the existing dispenser and billing logic; the per-user visit tracker counts each completed dispense.

---
 rtl/fluid_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/fluid_dispense_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/fluid_pkg.sv
// fluid_pkg: shared fluid codes, reject codes, FSM states and stock width for the dispense scheduler.
package fluid_pkg;
  localparam int STOCK_W = 16;
  localparam logic [1:0] FLUID_WATER   = 2'd0;
  localparam logic [1:0] FLUID_JUICE   = 2'd1;
  localparam logic [1:0] FLUID_CHEM    = 2'd2;
  localparam logic [1:0] FLUID_INVALID = 2'd3;
  localparam logic [1:0] REJ_NONE  = 2'd0;
  localparam logic [1:0] REJ_FLUID = 2'd1;
  localparam logic [1:0] REJ_STOCK = 2'd2;
  localparam logic [1:0] REJ_ZERO  = 2'd3;
  typedef enum logic [1:0] {IDLE, CHECK, POUR, DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requesting station at or after ptr (wrapping); one-hot grant plus index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          valid
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx = PW'((int'(ptr) + i) % N);
      end
    end
  end
  assign valid = |req;
endmodule

// File: rtl/fluid_dispense_scheduler.sv
// fluid_dispense_scheduler: round-robin shared nozzle with stock check and litre-paced pour.
// Optional DISPENSE_ABORT_EN adds an abort input that ends a pour early, charging whole litres only.
module fluid_dispense_scheduler
  import fluid_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int LITRE_CYCLES = 4,
  parameter int STOCK_INIT   = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   req_fluid,
  input  logic [8*N_REQ-1:0]   req_vol,
  input  logic                 restock,
`ifdef DISPENSE_ABORT_EN
  input  logic                 abort,
`endif
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 valve_open,
  output logic [1:0]           fluid_sel,
  output logic [7:0]           litres_done,
  output logic                 done,
  output logic                 reject,
  output logic [1:0]           reject_code,
  output logic [3*STOCK_W-1:0] stock_out
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = LITRE_CYCLES > 1 ? $clog2(LITRE_CYCLES) : 1;
  state_t r_state, w_nxt;
  logic [PW-1:0] r_ptr, w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic w_valid, w_wrap, w_last, w_abort;
  logic [7:0] r_vol;
  logic [CW-1:0] r_cnt;
  logic [2:0][STOCK_W-1:0] r_stock;
  logic [STOCK_W-1:0] w_avail;
  logic [1:0] w_rej;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (req),
    .ptr  (r_ptr),
    .grant(w_gnt),
    .idx  (w_idx),
    .valid(w_valid)
  );
`ifdef DISPENSE_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif
  assign stock_out = r_stock;
  assign w_wrap = r_state == POUR && r_cnt == CW'(LITRE_CYCLES - 1);
  assign w_last = w_wrap && litres_done + 8'd1 == r_vol;
  assign w_avail = fluid_sel == FLUID_CHEM ? r_stock[2] : fluid_sel == FLUID_JUICE ? r_stock[1] : r_stock[0];
  assign w_rej = fluid_sel == FLUID_INVALID ? REJ_FLUID :
                 r_vol == 8'd0 ? REJ_ZERO :
                 STOCK_W'(r_vol) > w_avail ? REJ_STOCK : REJ_NONE;
  always_comb begin
    w_nxt = IDLE;
    unique case (r_state)
      IDLE:    w_nxt = w_valid ? CHECK : IDLE;
      CHECK:   w_nxt = w_rej != REJ_NONE ? IDLE : POUR;
      POUR:    w_nxt = (w_last || w_abort) ? DONE : POUR;
      default: w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_vol <= '0;
      r_cnt <= '0;
      r_stock <= {3{STOCK_W'(STOCK_INIT)}};
      grant <= '0;
      busy <= 1'b0;
      valve_open <= 1'b0;
      fluid_sel <= '0;
      litres_done <= '0;
      done <= 1'b0;
      reject <= 1'b0;
      reject_code <= '0;
    end else begin
      r_state <= w_nxt;
      busy <= w_nxt != IDLE;
      valve_open <= w_nxt == POUR;
      grant <= r_state == IDLE ? w_gnt : '0;
      done <= r_state == POUR && w_nxt == DONE;
      reject <= r_state == CHECK && w_nxt == IDLE;
      if (r_state == CHECK && w_rej != REJ_NONE) reject_code <= w_rej;
      if (r_state == IDLE && w_valid) begin
        fluid_sel <= req_fluid[2*w_idx +: 2];
        r_vol <= req_vol[8*w_idx +: 8];
        litres_done <= '0;
        r_ptr <= w_idx == PW'(N_REQ - 1) ? '0 : w_idx + 1'b1;
      end else if (w_wrap) begin
        litres_done <= litres_done + 8'd1;
      end
      r_cnt <= (r_state != POUR || w_wrap) ? '0 : r_cnt + 1'b1;
      // restock wins over the old level but a coincident litre is still charged
      for (int f = 0; f < 3; f++)
        r_stock[f] <= (restock ? STOCK_W'(STOCK_INIT) : r_stock[f]) - STOCK_W'(w_wrap && fluid_sel == 2'(f));
    end
  end
endmodule
